// File: rtl/line_print_sequencer_pkg.sv
// Shared types and constants for the line print sequencer.
// State encoding, output characters and pointer-entry field layout.
package line_print_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PTR_WAIT = 4'd1,
    S_PTR_CAP  = 4'd2,
    S_LHS_WAIT = 4'd3,
    S_LHS_CAP  = 4'd4,
    S_LHS_OUT  = 4'd5,
    S_SEP_OUT  = 4'd6,
    S_RHS_WAIT = 4'd7,
    S_RHS_CAP  = 4'd8,
    S_RHS_OUT  = 4'd9,
    S_CR_OUT   = 4'd10,
    S_LF_OUT   = 4'd11,
    S_DONE     = 4'd12
  } state_t;

  localparam logic [7:0] SEP_CHAR = 8'h3D;
  localparam logic [7:0] CR_CHAR  = 8'h0D;
  localparam logic [7:0] LF_CHAR  = 8'h0A;

  localparam int LEN_MSB   = 15;
  localparam int LEN_LSB   = 8;
  localparam int START_MSB = 7;
  localparam int START_LSB = 0;

  localparam logic [7:0] IDLE_ADDR = 8'hFF;

  function automatic logic [7:0] ptr_len(input logic [15:0] e);
    return e[LEN_MSB:LEN_LSB];
  endfunction

  function automatic logic [7:0] ptr_start(input logic [15:0] e);
    return e[START_MSB:START_LSB];
  endfunction

endpackage

// File: rtl/line_print_sequencer_if.sv
// Pointer table, char-pair memory and output byte stream bundle.
// Master side is the sequencer; slave side is the memories and consumer.
interface line_print_sequencer_if;

  logic [7:0]  ptr_addr;
  logic [15:0] ptr_dout;
  logic [7:0]  mem_addr;
  logic [15:0] mem_dout;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output ptr_addr,
    input  ptr_dout,
    output mem_addr,
    input  mem_dout,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  ptr_addr,
    output ptr_dout,
    input  mem_addr,
    output mem_dout,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/char_out_reg.sv
// Single-entry output holding register with load/valid/ready.
// A load wins over a same-cycle handshake so bytes can go back to back.
module char_out_reg (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  logic [7:0] data_q;
  logic       valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/line_print_sequencer.sv
// Walks one line's char pairs twice (LHS then RHS) and streams
// the bytes with a separator between passes and CR/LF at the end.
module line_print_sequencer
  import line_print_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [7:0]             line_i,
  output logic                   busy_o,
  output logic                   done_o,
  line_print_sequencer_if.master bus
);

  state_t     state_q;
  logic [7:0] ptr_addr_q;
  logic [7:0] mem_addr_q;
  logic [7:0] base_q;
  logic [7:0] len_q;
  logic [7:0] idx_q;
  logic       busy_q;
  logic       done_q;

  logic       load_d;
  logic [7:0] ld_data_d;
  logic       hs;
  logic [7:0] nxt_idx;
  logic       last;
  logic [7:0] p_len;
  logic [7:0] p_start;

  assign hs      = bus.out_valid && bus.out_ready;
  assign nxt_idx = idx_q + 8'd1;
  assign last    = (nxt_idx == len_q);
  assign p_len   = ptr_len(bus.ptr_dout);
  assign p_start = ptr_start(bus.ptr_dout);

  // Load requests for the output register, issued on entry to each *_OUT state
  always_comb begin
    load_d    = 1'b0;
    ld_data_d = 8'h00;
    case (state_q)
      S_PTR_CAP: begin
        if (p_len == 8'd0) begin
          load_d    = 1'b1;
          ld_data_d = SEP_CHAR;
        end
      end
      S_LHS_CAP: begin
        load_d    = 1'b1;
        ld_data_d = bus.mem_dout[15:8];
      end
      S_LHS_OUT: begin
        if (hs && last) begin
          load_d    = 1'b1;
          ld_data_d = SEP_CHAR;
        end
      end
      S_SEP_OUT: begin
        if (hs && (len_q == 8'd0)) begin
          load_d    = 1'b1;
          ld_data_d = CR_CHAR;
        end
      end
      S_RHS_CAP: begin
        load_d    = 1'b1;
        ld_data_d = bus.mem_dout[7:0];
      end
      S_RHS_OUT: begin
        if (hs && last) begin
          load_d    = 1'b1;
          ld_data_d = CR_CHAR;
        end
      end
      S_CR_OUT: begin
        if (hs) begin
          load_d    = 1'b1;
          ld_data_d = LF_CHAR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_addr_q <= 8'h00;
      mem_addr_q <= IDLE_ADDR;
      base_q     <= 8'h00;
      len_q      <= 8'h00;
      idx_q      <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            ptr_addr_q <= line_i;
            busy_q     <= 1'b1;
            state_q    <= S_PTR_WAIT;
          end
        end
        S_PTR_WAIT: state_q <= S_PTR_CAP;
        S_PTR_CAP: begin
          base_q <= p_start;
          len_q  <= p_len;
          idx_q  <= 8'h00;
          if (p_len == 8'd0) begin
            state_q <= S_SEP_OUT;
          end else begin
            mem_addr_q <= p_start;
            state_q    <= S_LHS_WAIT;
          end
        end
        S_LHS_WAIT: state_q <= S_LHS_CAP;
        S_LHS_CAP:  state_q <= S_LHS_OUT;
        S_LHS_OUT: begin
          if (hs) begin
            idx_q <= nxt_idx;
            if (last) begin
              state_q <= S_SEP_OUT;
            end else begin
              mem_addr_q <= base_q + nxt_idx;
              state_q    <= S_LHS_WAIT;
            end
          end
        end
        S_SEP_OUT: begin
          if (hs) begin
            idx_q <= 8'h00;
            if (len_q == 8'd0) begin
              state_q <= S_CR_OUT;
            end else begin
              mem_addr_q <= base_q;
              state_q    <= S_RHS_WAIT;
            end
          end
        end
        S_RHS_WAIT: state_q <= S_RHS_CAP;
        S_RHS_CAP:  state_q <= S_RHS_OUT;
        S_RHS_OUT: begin
          if (hs) begin
            idx_q <= nxt_idx;
            if (last) begin
              state_q <= S_CR_OUT;
            end else begin
              mem_addr_q <= base_q + nxt_idx;
              state_q    <= S_RHS_WAIT;
            end
          end
        end
        S_CR_OUT: begin
          if (hs) state_q <= S_LF_OUT;
        end
        S_LF_OUT: begin
          if (hs) begin
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            mem_addr_q <= IDLE_ADDR;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  char_out_reg u_out (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load_d),
    .data_i  (ld_data_d),
    .ready_i (bus.out_ready),
    .data_o  (bus.out_data),
    .valid_o (bus.out_valid)
  );

  assign bus.ptr_addr = ptr_addr_q;
  assign bus.mem_addr = mem_addr_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
